// File: rtl/memory_copy_verify_engine_pkg.sv
// Shared types and helpers for the memory copy/verify engine.
// Latency: none (package only).
// Backpressure: none (package only).
package pztb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_COPY         = 3'd1,
    ST_COPY_DRAIN   = 3'd2,
    ST_VERIFY       = 3'd3,
    ST_VERIFY_DRAIN = 3'd4,
    ST_DONE         = 3'd5
  } memory_copy_state;

  // True when [base, base+len) lies inside a memory of 'depth' words without wrapping.
  function automatic logic range_fits(input int unsigned base,
                                      input int unsigned len,
                                      input int unsigned depth);
    return (base + len) <= depth;
  endfunction

endpackage

// File: rtl/memory_copy_verify_engine_delay_line.sv
// Valid+payload shift register that tracks reads in flight to the memory.
// Latency: exactly DEPTH cycles from i_vld to o_vld.
// Backpressure: none; payload stages only move when their valid moves, so o_dat holds when idle.
module tb_delay_line #(
  parameter int DEPTH = 1,
  parameter int PW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_vld,
  input  logic [PW-1:0] i_dat,
  output logic          o_vld,
  output logic [PW-1:0] o_dat,
  output logic          o_any
);

  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_dat [DEPTH];

  // Shift valid every cycle; advance payload only alongside a valid token.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) r_dat[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_dat = r_dat[DEPTH-1];
  assign o_any = |r_vld;

endmodule

// File: rtl/memory_copy_verify_engine.sv
// Block copy SRC->DST over a 2R1W memory port set, with optional SRC/DST compare pass.
// Latency: len+READ_LATENCY per pass plus a few FSM cycles; rejected/empty commands finish 1 cycle after accept.
// Backpressure: none; the memory is assumed always ready, i_start is ignored while a command runs.
module memory_copy_verify_engine
  import pztb_pkg::*;
#(
  parameter int DATAW        = 32,
  parameter int WORDW        = 1024,
  parameter int ADDRW        = $clog2(WORDW),
  parameter int READ_LATENCY = 1,
  parameter int CNTW         = ADDRW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_verify,
  input  logic [ADDRW-1:0] i_src,
  input  logic [ADDRW-1:0] i_dst,
  input  logic [CNTW-1:0]  i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [CNTW-1:0]  o_mismatch_count,
  output logic             o_first_mismatch_valid,
  output logic [ADDRW-1:0] o_first_mismatch_addr,
  output logic [ADDRW-1:0] adra,
  output logic [DATAW-1:0] da,
  output logic [DATAW-1:0] wema,
  output logic             wea,
  output logic             mea,
  output logic [ADDRW-1:0] adrb,
  output logic             meb,
  output logic [ADDRW-1:0] adrc,
  output logic             mec,
  input  logic [DATAW-1:0] qb,
  input  logic [DATAW-1:0] qc
);

  localparam int SW = CNTW + 1;

  memory_copy_state r_state, w_state_nxt;

  logic [ADDRW-1:0] r_src, r_dst;
  logic [CNTW-1:0]  r_len, r_idx;
  logic             r_verify, r_err;
  logic             r_cp_vld, r_vf_vld;
  logic [ADDRW-1:0] r_cp_dst, r_vf_off;
  logic [DATAW-1:0] r_da;
  logic [CNTW-1:0]  r_mm_cnt;
  logic             r_fm_vld;
  logic [ADDRW-1:0] r_fm_addr;

  logic [SW-1:0]    w_src_end;
  logic             w_cmd_bad, w_last, w_accept, w_copy_rd, w_vfy_rd;
  logic [ADDRW-1:0] w_off;
  logic             w_cdl_vld, w_cdl_any, w_vdl_vld, w_vdl_any;
  logic [ADDRW-1:0] w_cdl_dst, w_vdl_off;

  // A forward overlap (dst inside (src, src+len)) would read words already overwritten.
  assign w_src_end = SW'(i_src) + SW'(i_len);
  assign w_cmd_bad = !range_fits(32'(i_src), 32'(i_len), WORDW) ||
                     !range_fits(32'(i_dst), 32'(i_len), WORDW) ||
                     ((i_dst > i_src) && (SW'(i_dst) < w_src_end));
  assign w_last    = (r_idx == (r_len - CNTW'(1)));
  assign w_off     = r_idx[ADDRW-1:0];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and per-cycle read issue decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_copy_rd   = 1'b0;
    w_vfy_rd    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          if (w_cmd_bad || (i_len == '0)) w_state_nxt = ST_DONE;
          else                            w_state_nxt = ST_COPY;
        end
      end
      ST_COPY: begin
        w_copy_rd = 1'b1;
        if (w_last) w_state_nxt = ST_COPY_DRAIN;
      end
      ST_COPY_DRAIN: begin
        // Every write must retire before the verify pass reads DST back.
        if (!r_cp_vld && !w_cdl_any) w_state_nxt = r_verify ? ST_VERIFY : ST_DONE;
      end
      ST_VERIFY: begin
        w_vfy_rd = 1'b1;
        if (w_last) w_state_nxt = ST_VERIFY_DRAIN;
      end
      ST_VERIFY_DRAIN: begin
        if (!r_vf_vld && !w_vdl_any) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the command on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_verify <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_src    <= i_src;
      r_dst    <= i_dst;
      r_len    <= i_len;
      r_verify <= i_verify;
      r_err    <= w_cmd_bad;
    end
  end

  // Word index within the current pass; wraps to 0 after the last word so verify restarts at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_idx <= '0;
    else if (w_accept)               r_idx <= '0;
    else if (w_copy_rd || w_vfy_rd)  r_idx <= w_last ? '0 : r_idx + CNTW'(1);
  end

  // Registered read ports; addresses hold their last value when the port is idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meb      <= 1'b0;
      mec      <= 1'b0;
      adrb     <= '0;
      adrc     <= '0;
      r_cp_vld <= 1'b0;
      r_vf_vld <= 1'b0;
      r_cp_dst <= '0;
      r_vf_off <= '0;
    end else begin
      meb      <= w_copy_rd | w_vfy_rd;
      mec      <= w_vfy_rd;
      r_cp_vld <= w_copy_rd;
      r_vf_vld <= w_vfy_rd;
      if (w_copy_rd || w_vfy_rd) begin
        adrb     <= r_src + w_off;
        r_cp_dst <= r_dst + w_off;
        r_vf_off <= w_off;
      end
      if (w_vfy_rd) adrc <= r_dst + w_off;
    end
  end

  tb_delay_line #(.DEPTH(READ_LATENCY), .PW(ADDRW)) u_copy_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vld   (r_cp_vld),
    .i_dat   (r_cp_dst),
    .o_vld   (w_cdl_vld),
    .o_dat   (w_cdl_dst),
    .o_any   (w_cdl_any)
  );

  tb_delay_line #(.DEPTH(READ_LATENCY), .PW(ADDRW)) u_verify_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vld   (r_vf_vld),
    .i_dat   (r_vf_off),
    .o_vld   (w_vdl_vld),
    .o_dat   (w_vdl_off),
    .o_any   (w_vdl_any)
  );

  // Remember the last written word so da holds while the write port is idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_da <= '0;
    else if (w_cdl_vld) r_da <= qb;
  end

  // Mismatch count (saturating) and first-mismatch offset; cleared by every accepted command.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mm_cnt  <= '0;
      r_fm_vld  <= 1'b0;
      r_fm_addr <= '0;
    end else if (w_accept) begin
      r_mm_cnt  <= '0;
      r_fm_vld  <= 1'b0;
      r_fm_addr <= '0;
    end else if (w_vdl_vld && (qb != qc)) begin
      if (r_mm_cnt != '1) r_mm_cnt <= r_mm_cnt + CNTW'(1);
      if (!r_fm_vld) begin
        r_fm_vld  <= 1'b1;
        r_fm_addr <= w_vdl_off;
      end
    end
  end

  assign mea  = w_cdl_vld;
  assign wea  = w_cdl_vld;
  assign adra = w_cdl_dst;
  assign da   = w_cdl_vld ? qb : r_da;
  assign wema = '1;

  assign o_busy                 = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_done                 = (r_state == ST_DONE);
  assign o_error                = (r_state == ST_DONE) && r_err;
  assign o_mismatch_count       = r_mm_cnt;
  assign o_first_mismatch_valid = r_fm_vld;
  assign o_first_mismatch_addr  = r_fm_addr;

endmodule
